// File: rtl/div_pkg.sv
// Shared types and constants for the shared iterative divider controller.
`timescale 1ns/1ps
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_REQ   = 2;
    localparam int MAX_WIDTH = 64;

    // Divide-by-zero returns all-ones for both quotient and remainder; sliced to WIDTH by users.
    localparam logic [MAX_WIDTH-1:0] DIV0_RESULT = '1;

endpackage

// File: rtl/div_iter_core.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
`timescale 1ns/1ps
module div_iter_core
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH:0]   shifted;

    // The stored remainder is always below the divisor, so WIDTH bits hold it; only the
    // shifted trial value needs the extra bit.
    always_comb begin
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        if (start_i) begin
            dvd_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = CW'(WIDTH - 1);
            if (divisor_i == '0) begin
                quot_d = DIV0_RESULT[WIDTH-1:0];
                rem_d  = DIV0_RESULT[WIDTH-1:0];
                run_d  = 1'b0;
            end else begin
                quot_d = '0;
                rem_d  = '0;
                run_d  = 1'b1;
            end
        end else if (run_q) begin
            dvd_d = dvd_q << 1;
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d  = WIDTH'(shifted - {1'b0, dvs_q});
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = shifted[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one iterative divider between two requesters.
`timescale 1ns/1ps
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [WIDTH-1:0]   req0_dividend,
    input  logic [WIDTH-1:0]   req0_divisor,
    input  logic [WIDTH-1:0]   req1_dividend,
    input  logic [WIDTH-1:0]   req1_divisor,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_quot,
    output logic [WIDTH-1:0]   rsp_rem,
    output logic               busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the sender holds payload steady until the transfer.
    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic             gnt_any, gnt_idx, accept;
    logic [WIDTH-1:0] sel_dvd, sel_dvs;
    logic             core_done;
    logic [WIDTH-1:0] core_quot, core_rem;

    always_comb begin
        gnt_any   = |req_valid;
        gnt_idx   = (&req_valid) ? ~last_q : req_valid[1];
        req_ready = (state_q == IDLE && gnt_any) ? (2'b01 << gnt_idx) : 2'b00;
        accept    = |(req_valid & req_ready);
        sel_dvd   = gnt_idx ? req1_dividend : req0_dividend;
        sel_dvs   = gnt_idx ? req1_divisor  : req0_divisor;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = gnt_idx;
                    last_d  = gnt_idx;
                    state_d = (sel_dvs == '0) ? DONE : RUN;
                end
            end
            RUN:     if (core_done) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
        end
    end

    div_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (accept),
        .dividend_i (sel_dvd),
        .divisor_i  (sel_dvs),
        .done_o     (core_done),
        .quot_o     (core_quot),
        .rem_o      (core_rem)
    );

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_quot  = core_quot;
    assign rsp_rem   = core_rem;

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Sequencing and arbitration controller that shares one iterative (one bit per cycle) restoring unsigned divider between two requesters.
- Each requester presents dividend/divisor on a valid/ready request channel.
- Controller arbitrates round-robin, runs the divide over WIDTH cycles, and returns quotient/remainder with the requester ID on a single valid/ready response channel.
- Replaces the fully combinational divider where area matters more than latency.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (legal ≥ 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester request ready.
- req0_dividend  input  WIDTH  requester 0 dividend.
- req0_divisor  input  WIDTH  requester 0 divisor.
- req1_dividend  input  WIDTH  requester 1 dividend.
- req1_divisor  input  WIDTH  requester 1 divisor.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  index of the requester whose operation produced the result.
- rsp_quot  output  WIDTH  quotient.
- rsp_rem  output  WIDTH  remainder.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- **Reset values**
  - state = IDLE, req_ready = 0 combinationally unless granted, rsp_valid = 0.
  - rsp_id = 0, rsp_quot = 0, rsp_rem = 0, busy = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
- **States:** IDLE, RUN, DONE.
- **Grant (combinational, IDLE only)**
  - Only one valid: grant it.
  - Both valid: grant the index != last.
  - req_ready[i] = (state == IDLE) && granted == i; at most one bit high; both 0 outside IDLE.
- **Accept** (req_valid[i] && req_ready[i] at edge)
  - Latch operands and id = i; set last = i.
  - Divisor == 0: go directly to DONE with rsp_quot = all-ones, rsp_rem = all-ones.
  - Otherwise: clear the partial remainder (WIDTH+1 bits) and the quotient, load count = WIDTH-1, go to RUN.
- **RUN** (one iteration per cycle, MSB first)
  - A' = {A, dividend_bit}.
  - If A' ≥ divisor: A = A' − divisor, shift 1 into quotient; else A = A', shift 0.
  - On the cycle count == 0, go to DONE.
  - Otherwise decrement count.
  - Exactly WIDTH RUN cycles.
- **DONE**
  - rsp_valid = 1; rsp_id/rsp_quot/rsp_rem are registered and stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
  - rsp_quot/rsp_rem keep their last value after the handshake (don't-care to consumers).
- **Latency** (accept edge = cycle 0)
  - Normal divide: rsp_valid first high in cycle WIDTH+1.
  - Divide-by-zero: rsp_valid first high in cycle 1.
- **Throughput:** next accept is no earlier than the cycle after the response handshake; a new request is never accepted in the same cycle as a response handshake.
- **Request hold rule:** requesters hold req_valid and operands until accepted; the controller does not read operands except at the accept edge.
- **Request changes while not ready:** operand changes while req_ready = 0 have no effect.
- **Reset mid-RUN or mid-DONE:**
  - Immediately returns to IDLE, drops rsp_valid and resets last.
  - The in-flight operation is lost; no response is produced.
- **Arithmetic**
  - Results equal floor(dividend/divisor) and dividend mod divisor for divisor ≠ 0.
  - The partial remainder needs WIDTH+1 bits to hold the shifted value before subtraction.

Decomposition:
- **Shared package div_pkg**
  - State enum (IDLE, RUN, DONE).
  - Divide-by-zero result constant (all-ones of WIDTH).
  - Requester-count constant NUM_REQ = 2.
- **Sub-module div_iter_core**
  - Holds the partial remainder, quotient and iteration counter.
  - Ports: start, dividend, divisor, done, quot, rem.
- **Top:** div_share_ctrl keeps the arbiter, FSM and response registers.

Test Plan:
- Single op, WIDTH = 8: req0 200/7 accepted cycle 0 -> rsp_valid in cycle 9, rsp_id = 0, quot = 28, rem = 4; busy high cycles 1–9.
- Divide-by-zero: req1 5/0 -> rsp_valid in cycle 1, rsp_id = 1, quot = 0xFF, rem = 0xFF; no RUN cycles.
- Tie and fairness: both valid from reset (req0 10/3, req1 255/16) -> req0 first (3, 1), then req1 (15, 15); with both still valid for a third op, grant returns to req0.
- Boundaries: 255/1 -> 255, 0; 3/200 -> 0, 3; 0/9 -> 0, 0; 255/255 -> 1, 0.
- Backpressure: hold rsp_ready = 0 for 5 cycles in DONE -> rsp_valid and data stable, req_ready = 00 throughout; accept on release, IDLE the next cycle.
- Reset mid-RUN: assert rst in RUN cycle 4 -> rsp_valid = 0 and busy = 0 immediately; no stale response afterwards; the next tie is granted to req0.
